// File: rtl/sdram_pkg.sv
// Shared definitions for the byte-wide SDRAM controller and its host-side word bridge.
package sdram_pkg;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } bridge_state_t;

  // Controller command encoding {cs_n, ras_n, cas_n, we_n} and timing in clocks
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam int T_RCD = 2;
  localparam int T_CAS = 2;
  localparam int T_RP  = 2;
  localparam int T_RFC = 7;
endpackage

// File: rtl/sdram_word_bridge_be_next_idx.sv
// Finds the next enabled byte lane at or above (incl=1) / strictly above (incl=0) idx.
import sdram_pkg::*;

module be_next_idx (
  input  logic [WORD_BYTES-1:0] be,
  input  logic [1:0]            idx,
  input  logic                  incl,
  output logic [1:0]            nxt,
  output logic                  none
);
  // Scanning downward lets the lowest qualifying lane win.
  always_comb begin
    nxt  = 2'd0;
    none = 1'b1;
    for (int k = WORD_BYTES - 1; k >= 0; k--) begin
      if (be[k] && ((k > int'(idx)) || (incl && (k == int'(idx))))) begin
        nxt  = 2'(k);
        none = 1'b0;
      end
    end
  end
endmodule

// File: rtl/sdram_word_bridge.sv
// Serializes 32-bit host word requests into single-byte SDRAM controller ops, ascending lane order.
import sdram_pkg::*;

module sdram_word_bridge #(
  parameter int ADDR_DEPTH = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_DEPTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_DEPTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  input  logic                  mem_rdy,
  input  logic                  mem_val,
  input  logic [7:0]            mem_rdata
);
  bridge_state_t         state_q, state_d;
  logic [ADDR_DEPTH-3:0] word_q, word_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d;
  logic [1:0]            idx_q, idx_d;
  logic [1:0]            first_idx, next_idx;
  logic                  first_none, next_none;
  logic                  unused_addr_lsb;

  assign unused_addr_lsb = ^req_addr[1:0];

  be_next_idx u_first (.be(req_be), .idx(2'd0),  .incl(1'b1), .nxt(first_idx), .none(first_none));
  be_next_idx u_next  (.be(be_q),   .idx(idx_q), .incl(1'b0), .nxt(next_idx),  .none(next_none));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          word_d  = req_addr[ADDR_DEPTH-1:2];
          wdata_d = req_wdata;
          be_d    = req_be;
          we_d    = req_we;
          rdata_d = '0;
          idx_d   = first_idx;
          // An empty write completes immediately; an empty read still owes a response.
          if (!first_none)  state_d = ST_ISSUE;
          else if (!req_we) state_d = ST_RESP;
        end
      end
      ST_ISSUE: begin
        if (mem_rdy) begin
          if (!we_q)          state_d = ST_WAIT_RD;
          else if (next_none) state_d = ST_IDLE;
          else                idx_d   = next_idx;
        end
      end
      ST_WAIT_RD: begin
        if (mem_val) begin
          rdata_d[{idx_q, 3'b000} +: 8] = mem_rdata;
          if (next_none) state_d = ST_RESP;
          else begin
            idx_d   = next_idx;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign mem_rd    = (state_q == ST_ISSUE) && !we_q;
  assign mem_wr    = (state_q == ST_ISSUE) && we_q;
  assign mem_addr  = {word_q, idx_q};
  assign mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
endmodule

// File: tb/tb_sdram_word_bridge.sv
// Scoreboard bench: directed requests against a byte-wide controller model with busy/val timing.
module tb_sdram_word_bridge;
  localparam int AD   = 25;
  localparam int BUSY = 4;
  localparam int VDLY = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AD-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic [AD-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;
  logic          mem_rd, mem_wr, mem_rdy, mem_val;

  // Controller model state
  logic [7:0] mem [0:4095];
  int         busy = 0, val_cnt = 0;
  logic       val_q = 1'b0, inj_val = 1'b0, stall = 1'b0;
  logic [7:0] rd_q = '0, inj_data = '0;

  logic [34:0] exp_op[$];
  logic [31:0] exp_rsp[$];
  int n_vec = 0, n_bad = 0;

  sdram_word_bridge #(.ADDR_DEPTH(AD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdy(mem_rdy), .mem_val(mem_val), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdy   = (busy == 0) && !stall;
  assign mem_val   = val_q | inj_val;
  assign mem_rdata = inj_val ? inj_data : rd_q;

  always @(posedge clk) begin
    if (rst) begin
      busy    <= 0;
      val_cnt <= 0;
      val_q   <= 1'b0;
    end else begin
      val_q <= 1'b0;
      if (busy != 0) busy <= busy - 1;
      if (val_cnt != 0) begin
        val_cnt <= val_cnt - 1;
        if (val_cnt == 1) val_q <= 1'b1;
      end
      if (mem_rdy && (mem_rd || mem_wr)) begin
        busy <= BUSY;
        if (mem_wr) mem[mem_addr[11:0]] = mem_wdata;
        else begin
          rd_q    <= mem[mem_addr[11:0]];
          val_cnt <= VDLY;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [34:0] op(input logic we, input logic [AD-1:0] a, input logic [7:0] d);
    return {~we, we, a, d};
  endfunction

  // Monitor: every controller accept and every response handshake is checked against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rdy && (mem_rd || mem_wr)) begin
        if (exp_op.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL op_unexpected: got %0h expected none", {mem_rd, mem_wr, mem_addr, mem_wdata});
        end else chk("mem_op", {mem_rd, mem_wr, mem_addr, mem_wdata}, exp_op.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL rsp_unexpected: got %0h expected none", rsp_rdata);
        end else chk("rsp_data", rsp_rdata, exp_rsp.pop_front());
      end
    end
  end

  // Returns at #1 after the accepting edge T.
  task automatic send(input logic we, input logic [AD-1:0] a, input logic [31:0] d, input logic [3:0] be);
    int t = 0;
    @(posedge clk); #1;
    req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
    do begin @(negedge clk); t++; end while (!req_ready && t < 500);
    if (!req_ready) chk("req_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Returns at the negedge just before the n-th accept edge.
  task automatic wait_accepts(input int n);
    int seen = 0, t = 0;
    while (seen < n && t < 500) begin
      @(negedge clk); t++;
      if (mem_rdy && (mem_rd || mem_wr)) seen++;
    end
    if (seen < n) chk("accept_timeout", seen, n);
  endtask

  task automatic take_rsp();
    int t = 0;
    while (!rsp_valid && t < 500) begin @(negedge clk); t++; end
    if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nv;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h300] = 8'h01; mem[12'h301] = 8'h02; mem[12'h302] = 8'h03; mem[12'h303] = 8'h04;
    mem[12'h601] = 8'h5A; mem[12'h700] = 8'h77;

    repeat (2) @(posedge clk); #1;
    chk("rst_flags", {req_ready, rsp_valid, mem_rd, mem_wr}, 4'b1000);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst = 1'b0;

    // Full write
    exp_op.push_back(op(1, 25'h100, 8'hAA)); exp_op.push_back(op(1, 25'h101, 8'hBB));
    exp_op.push_back(op(1, 25'h102, 8'hCC)); exp_op.push_back(op(1, 25'h103, 8'hDD));
    send(1, 25'h100, 32'hDDCCBBAA, 4'b1111);
    wait_accepts(4);
    chk("full_wr_busy", req_ready, 0);
    @(negedge clk);
    chk("full_wr_ready", req_ready, 1);

    // Sparse write
    exp_op.push_back(op(1, 25'h200, 8'h11)); exp_op.push_back(op(1, 25'h202, 8'h33));
    send(1, 25'h200, 32'h44332211, 4'b0101);
    wait_accepts(2);
    @(negedge clk);
    chk("sparse_ready", req_ready, 1);

    // Read assemble
    for (int i = 0; i < 4; i++) exp_op.push_back(op(0, 25'h300 + 25'(i), 8'h00));
    exp_rsp.push_back(32'h04030201);
    send(0, 25'h300, 32'h0, 4'b1111);
    nv = 0;
    for (int t = 0; t < 500 && nv < 4; t++) begin
      @(negedge clk);
      if (mem_val) nv++;
    end
    chk("rd_val_count", nv, 4);
    chk("rd_rsp_early", rsp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rd_rsp_hold", {rsp_valid, rsp_rdata}, {1'b1, 32'h04030201});
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("rd_ready_back", req_ready, 1);

    // Empty write, then empty read
    send(1, 25'h400, 32'h12345678, 4'b0000);
    @(negedge clk);
    chk("be0_wr", {req_ready, mem_wr}, 2'b10);
    exp_rsp.push_back(32'h0);
    send(0, 25'h500, 32'h0, 4'b0000);
    @(negedge clk);
    chk("be0_rd", {rsp_valid, rsp_rdata}, {1'b1, 32'h0});
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;

    // Refresh stall on a single-lane read
    stall = 1'b1;
    exp_op.push_back(op(0, 25'h601, 8'h00));
    exp_rsp.push_back(32'h00005A00);
    send(0, 25'h600, 32'h0, 4'b0010);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_hold", {mem_rd, mem_wr, mem_addr, mem_wdata}, {2'b10, 25'h601, 8'h00});
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("stall_single", {mem_rd, mem_wr}, 2'b00);
    take_rsp();

    // Reset while waiting for read data
    exp_op.push_back(op(0, 25'h700, 8'h00));
    send(0, 25'h700, 32'h0, 4'b0001);
    wait_accepts(1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_flags", {req_ready, rsp_valid, mem_rd, mem_wr}, 4'b1000);
    chk("midrst_bus", {mem_addr, mem_wdata, rsp_rdata}, 0);
    rst = 1'b0; inj_val = 1'b1; inj_data = 8'hEE;
    @(posedge clk); #1 inj_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_quiet", {req_ready, rsp_valid, mem_rd}, 3'b100);
    end
    exp_op.push_back(op(0, 25'h300, 8'h00));
    exp_rsp.push_back(32'h00000001);
    send(0, 25'h300, 32'h0, 4'b0001);
    take_rsp();

    repeat (10) @(negedge clk);
    chk("ops_drained", exp_op.size(), 0);
    chk("rsps_drained", exp_rsp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
